// File: rtl/spiflash_responder_if.sv
// -----------------------------------------------------------------------------
// spiflash_responder_if
// Bundles the SPI pins, the byte-wide backing-memory port and the status
// flags of spiflash_responder.
//   spi_csb, spi_sck, spi_sdi : host -> flash serial lines (async to core_clk)
//   spi_sdo, spi_sdoenb       : flash -> host data and its active-low enable
//   mem_rd, mem_addr          : one-cycle read strobe and byte address
//   mem_rdata                 : read data, valid one core_clk after mem_rd
//   powered_down, busy        : status flags
// Modports:
//   slave  - the responder itself
//   master - the environment (SPI host plus backing memory)
// -----------------------------------------------------------------------------
interface spiflash_responder_if #(
  parameter int MEM_AW = 16
);
  logic              spi_csb;
  logic              spi_sck;
  logic              spi_sdi;
  logic              spi_sdo;
  logic              spi_sdoenb;
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              powered_down;
  logic              busy;

  modport slave (
    input  spi_csb, spi_sck, spi_sdi, mem_rdata,
    output spi_sdo, spi_sdoenb, mem_rd, mem_addr, powered_down, busy
  );

  modport master (
    output spi_csb, spi_sck, spi_sdi, mem_rdata,
    input  spi_sdo, spi_sdoenb, mem_rd, mem_addr, powered_down, busy
  );
endinterface

// File: rtl/spiflash_responder.sv
// -----------------------------------------------------------------------------
// spiflash_responder
// SPI flash slave (mode 0, single-bit IO). csb/sck/sdi are oversampled on
// core_clk; READ (0x03), FAST READ (0x0B), release power-down (0xAB) and
// power-down (0xB9) are decoded, and read data is streamed from an external
// byte-wide synchronous memory. Any other opcode is ignored until csb rises.
// Ports:
//   core_clk  - sole clock
//   core_rst  - synchronous, active-high reset
//   bus       - spiflash_responder_if.slave (SPI pins, memory port, status)
// Parameters:
//   MEM_AW      - backing memory byte-address width (8..24); the 24-bit SPI
//                 address is truncated to its MEM_AW LSBs
//   SYNC_STAGES - synchronizer depth on the SPI inputs (2..3)
// -----------------------------------------------------------------------------
module spiflash_responder #(
  parameter int MEM_AW      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 core_clk,
  input  logic                 core_rst,
  spiflash_responder_if.slave  bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_RPD  = 8'hAB;
  localparam logic [7:0] OP_PD   = 8'hB9;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] csb_sync_r;
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] sdi_sync_r;
  logic                   csb_prev_r;
  logic                   sck_prev_r;

  // Decoded events
  logic csb_hi_s;
  logic csb_fall_s;
  logic sck_cur_s;
  logic sck_rise_s;
  logic sck_fall_s;
  logic sdi_s;

  // FSM and datapath
  logic [2:0]        state_r;
  logic [2:0]        state_nx_s;
  logic [4:0]        bit_cnt_r;
  // Only the last MEM_AW-1 shifted bits are kept: together with the live sdi
  // bit they form either the opcode (low 8) or the truncated address.
  logic [MEM_AW-2:0] sh_r;
  logic [7:0]        opcode_s;
  logic [MEM_AW-1:0] addr_s;
  logic              fast_r;
  logic              load_pend_r;
  logic [7:0]        out_sh_r;
  logic              issue_rd_s;
  logic              pd_set_s;
  logic              pd_clr_s;
  logic              counting_s;
  logic              phase_end_s;

  // Registered outputs
  logic              sdo_r;
  logic              sdoenb_r;
  logic              mem_rd_r;
  logic [MEM_AW-1:0] mem_addr_r;
  logic              pd_r;
  logic              busy_r;

  assign csb_hi_s   = csb_sync_r[SYNC_STAGES-1];
  assign csb_fall_s = csb_prev_r & ~csb_hi_s;
  assign sck_cur_s  = sck_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_cur_s & ~sck_prev_r;
  assign sck_fall_s = ~sck_cur_s & sck_prev_r;
  assign sdi_s      = sdi_sync_r[SYNC_STAGES-1];
  assign opcode_s   = {sh_r[6:0], sdi_s};
  assign addr_s     = {sh_r, sdi_s};

  // Synchronize the asynchronous SPI inputs and keep one sample of history
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      csb_sync_r <= {SYNC_STAGES{1'b1}};
      sck_sync_r <= {SYNC_STAGES{1'b0}};
      sdi_sync_r <= {SYNC_STAGES{1'b0}};
      csb_prev_r <= 1'b1;
      sck_prev_r <= 1'b0;
    end else begin
      csb_sync_r <= {csb_sync_r[SYNC_STAGES-2:0], bus.spi_csb};
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], bus.spi_sck};
      sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], bus.spi_sdi};
      csb_prev_r <= csb_hi_s;
      sck_prev_r <= sck_cur_s;
    end
  end

  // Next-state, read-issue and power-down decisions; csb high overrides all
  always_comb begin
    state_nx_s  = state_r;
    issue_rd_s  = 1'b0;
    pd_set_s    = 1'b0;
    pd_clr_s    = 1'b0;
    counting_s  = 1'b0;
    phase_end_s = 1'b0;
    if (csb_hi_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (csb_fall_s) begin
            state_nx_s = ST_CMD;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          counting_s = 1'b1;
          if (sck_rise_s && (bit_cnt_r == 5'd7)) begin
            phase_end_s = 1'b1;
            // 0xAB is the only opcode honoured while powered down
            if (opcode_s == OP_RPD) begin
              pd_clr_s   = 1'b1;
              state_nx_s = ST_IGNORE;
            end else if (pd_r) begin
              state_nx_s = ST_IGNORE;
            end else if ((opcode_s == OP_READ) || (opcode_s == OP_FAST)) begin
              state_nx_s = ST_ADDR;
            end else if (opcode_s == OP_PD) begin
              pd_set_s   = 1'b1;
              state_nx_s = ST_IGNORE;
            end else begin
              state_nx_s = ST_IGNORE;
            end
          end else begin
            state_nx_s = ST_CMD;
          end
        end
        ST_ADDR: begin
          counting_s = 1'b1;
          if (sck_rise_s && (bit_cnt_r == 5'd23)) begin
            phase_end_s = 1'b1;
            if (fast_r) begin
              state_nx_s = ST_DUMMY;
            end else begin
              issue_rd_s = 1'b1;
              state_nx_s = ST_DATA;
            end
          end else begin
            state_nx_s = ST_ADDR;
          end
        end
        ST_DUMMY: begin
          counting_s = 1'b1;
          if (sck_rise_s && (bit_cnt_r == 5'd7)) begin
            phase_end_s = 1'b1;
            issue_rd_s  = 1'b1;
            state_nx_s  = ST_DATA;
          end else begin
            state_nx_s = ST_DUMMY;
          end
        end
        ST_DATA: begin
          counting_s = 1'b1;
          // Fetch the next byte on the last rise so the stream has no gap
          if (sck_rise_s && (bit_cnt_r == 5'd7)) begin
            phase_end_s = 1'b1;
            issue_rd_s  = 1'b1;
          end else begin
            issue_rd_s = 1'b0;
          end
          state_nx_s = ST_DATA;
        end
        ST_IGNORE: begin
          state_nx_s = ST_IGNORE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state, bit counter, shifters, memory port and SPI output registers
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      bit_cnt_r   <= 5'd0;
      sh_r        <= {(MEM_AW-1){1'b0}};
      fast_r      <= 1'b0;
      load_pend_r <= 1'b0;
      out_sh_r    <= 8'h00;
      sdo_r       <= 1'b0;
      sdoenb_r    <= 1'b1;
      mem_rd_r    <= 1'b0;
      mem_addr_r  <= {MEM_AW{1'b0}};
      pd_r        <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      busy_r   <= (state_nx_s != ST_IDLE);
      mem_rd_r <= issue_rd_s;
      if (pd_set_s) begin
        pd_r <= 1'b1;
      end else if (pd_clr_s) begin
        pd_r <= 1'b0;
      end
      if (csb_hi_s) begin
        // Abort: tri-state the output and drop any read still in flight
        bit_cnt_r   <= 5'd0;
        sdoenb_r    <= 1'b1;
        load_pend_r <= 1'b0;
      end else begin
        load_pend_r <= mem_rd_r;
        if (counting_s && sck_rise_s) begin
          bit_cnt_r <= phase_end_s ? 5'd0 : (bit_cnt_r + 5'd1);
          sh_r      <= {sh_r[MEM_AW-3:0], sdi_s};
        end
        if ((state_r == ST_CMD) && phase_end_s) begin
          fast_r <= (opcode_s == OP_FAST);
        end
        if ((state_r == ST_ADDR) && phase_end_s) begin
          mem_addr_r <= addr_s;
        end
        // Read data arrives one cycle after the strobe; sck is slow enough
        // that the following fall can never land on this cycle.
        if (load_pend_r) begin
          out_sh_r   <= bus.mem_rdata;
          mem_addr_r <= mem_addr_r + MEM_AW'(1);
        end else if ((state_r == ST_DATA) && sck_fall_s) begin
          sdoenb_r <= 1'b0;
          sdo_r    <= out_sh_r[7];
          out_sh_r <= {out_sh_r[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.spi_sdo      = sdo_r;
  assign bus.spi_sdoenb   = sdoenb_r;
  assign bus.mem_rd       = mem_rd_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.powered_down = pd_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_spiflash_responder.sv
// -----------------------------------------------------------------------------
// tb_spiflash_responder
// Directed bench for spiflash_responder: an SPI mode-0 host, a 64 KiB
// synchronous memory, and a model that expects read strobes at the plain
// arithmetic addresses of each transfer and forbids output enable outside
// data phases.
// -----------------------------------------------------------------------------
module tb_spiflash_responder;

  localparam int MEM_AW      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 50;   // sck half period = 5 core_clk cycles

  logic core_clk;
  logic core_rst;

  spiflash_responder_if #(.MEM_AW(MEM_AW)) ifc ();

  spiflash_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .bus      (ifc.slave)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_q [$];
  logic [7:0]  got [0:7];
  logic        chk_en;
  logic        oe_allowed;
  logic        oe_seen;
  int          n_cmp;
  int          n_bad;

  // Backing memory: synchronous read, data valid one cycle after mem_rd
  always @(posedge core_clk) begin
    if (ifc.mem_rd) ifc.mem_rdata <= mem[ifc.mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle compare: every strobe must match the next expected address,
  // and outside data phases the output must stay disabled.
  always @(negedge core_clk) begin
    if (chk_en) begin
      if (ifc.mem_rd) begin
        if (exp_q.size() == 0) begin
          chk("mem_rd_unexpected", 32'(ifc.mem_rd), 32'd0);
        end else begin
          chk("mem_rd_addr", 32'(ifc.mem_addr), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (!oe_allowed) chk("sdoenb_idle", 32'(ifc.spi_sdoenb), 32'd1);
    end
  end

  // Shift nbits MSB-first; host samples sdo on the rise. With last set, csb
  // rises together with the final sck rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit last,
                          input bit data, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      ifc.spi_sdi = tx[7-i];
      #(HALF);
      ifc.spi_sck = 1'b1;
      if (last && (i == nbits - 1)) ifc.spi_csb = 1'b1;
      rx[7-i] = ifc.spi_sdo;
      if (data) oe_seen = oe_seen | ifc.spi_sdoenb;
      #(HALF);
      ifc.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    @(negedge core_clk);
    ifc.spi_csb = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    ifc.spi_csb = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge core_clk);
    oe_allowed = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op);
    logic [7:0] rx;
    cs_begin();
    spi_bits(op, 8, 1'b0, 1'b0, rx);
    cs_end();
  endtask

  // Full READ/FAST READ of n bytes; csb rises with the last data rise so no
  // prefetch strobe follows.
  task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int n);
    logic [7:0]  rx;
    logic [15:0] base;
    base = a[15:0];
    for (int k = 0; k < n; k++) exp_q.push_back(base + 16'(k));
    cs_begin();
    spi_bits(op,       8, 1'b0, 1'b0, rx);
    spi_bits(a[23:16], 8, 1'b0, 1'b0, rx);
    spi_bits(a[15:8],  8, 1'b0, 1'b0, rx);
    if (op == 8'h0B) begin
      spi_bits(a[7:0], 8, 1'b0, 1'b0, rx);
      oe_allowed = 1'b1;
      spi_bits(8'h00, 8, 1'b0, 1'b0, rx);
    end else begin
      oe_allowed = 1'b1;
      spi_bits(a[7:0], 8, 1'b0, 1'b0, rx);
    end
    for (int k = 0; k < n; k++) begin
      oe_seen = 1'b0;
      spi_bits(8'h00, 8, (k == n - 1), 1'b1, rx);
      got[k] = rx;
      chk("read_byte", 32'(rx), 32'(mem[base + 16'(k)]));
      chk("sdoenb_data", 32'(oe_seen), 32'd0);
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] b21;
    n_cmp = 0;
    n_bad = 0;
    chk_en = 1'b0;
    oe_allowed = 1'b0;
    oe_seen = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h3C;
    mem[16'h0012] = 8'h01;
    mem[16'h0013] = 8'hFF;
    mem[16'hFFFF] = 8'h96;
    mem[16'h0000] = 8'h69;
    ifc.spi_csb = 1'b1;
    ifc.spi_sck = 1'b0;
    ifc.spi_sdi = 1'b0;
    core_rst = 1'b1;

    // Reset
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_sdoenb", 32'(ifc.spi_sdoenb), 32'd1);
    chk("rst_mem_rd", 32'(ifc.mem_rd), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_pd", 32'(ifc.powered_down), 32'd0);
    chk("rst_sdo", 32'(ifc.spi_sdo), 32'd0);
    chk("rst_mem_addr", 32'(ifc.mem_addr), 32'd0);
    core_rst = 1'b0;
    repeat (2) @(negedge core_clk);
    chk_en = 1'b1;

    // READ 0x03 @0x10, four bytes
    do_read(8'h03, 24'h000010, 4);
    chk("read_b0", 32'(got[0]), 32'hA5);
    chk("read_b1", 32'(got[1]), 32'h3C);
    chk("read_b2", 32'(got[2]), 32'h01);
    chk("read_b3", 32'(got[3]), 32'hFF);
    chk("read_busy_end", 32'(ifc.busy), 32'd0);
    chk("read_strobes", 32'(exp_q.size()), 32'd0);

    // FAST READ @0xFFFF: address wraps to 0 without a gap
    do_read(8'h0B, 24'h00FFFF, 2);
    chk("fast_b0", 32'(got[0]), 32'h96);
    chk("fast_b1", 32'(got[1]), 32'h69);
    chk("fast_strobes", 32'(exp_q.size()), 32'd0);

    // Truncated 0xB9 (4 bits) must not power down
    cs_begin();
    spi_bits(8'hB9, 4, 1'b0, 1'b0, rx);
    cs_end();
    chk("trunc_pd", 32'(ifc.powered_down), 32'd0);

    // Power-down blocks READ, release restores it
    send_cmd(8'hB9);
    chk("pd_set", 32'(ifc.powered_down), 32'd1);
    cs_begin();
    spi_bits(8'h03, 8, 1'b0, 1'b0, rx);
    for (int k = 0; k < 5; k++) spi_bits(8'h00, 8, 1'b0, 1'b0, rx);
    chk("pd_busy", 32'(ifc.busy), 32'd1);
    cs_end();
    chk("pd_hold", 32'(ifc.powered_down), 32'd1);
    send_cmd(8'hAB);
    chk("pd_release", 32'(ifc.powered_down), 32'd0);
    do_read(8'h03, 24'h000012, 1);
    chk("post_release", 32'(got[0]), 32'h01);

    // Abort after 4 bits of the second byte
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h0021);
    b21 = mem[16'h0021];
    cs_begin();
    spi_bits(8'h03, 8, 1'b0, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, 1'b0, rx);
    oe_allowed = 1'b1;
    spi_bits(8'h20, 8, 1'b0, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, 1'b1, rx);
    chk("abort_b0", 32'(rx), 32'(mem[16'h0020]));
    spi_bits(8'h00, 4, 1'b0, 1'b1, rx);
    chk("abort_b1_hi", 32'(rx[7:4]), 32'(b21[7:4]));
    ifc.spi_csb = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge core_clk);
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_sdoenb", 32'(ifc.spi_sdoenb), 32'd1);
    cs_end();
    chk("abort_strobes", 32'(exp_q.size()), 32'd0);
    do_read(8'h03, 24'h000010, 2);
    chk("after_abort_b0", 32'(got[0]), 32'hA5);
    chk("after_abort_b1", 32'(got[1]), 32'h3C);

    // Unknown opcode 0x9F followed by 32 clocks
    cs_begin();
    spi_bits(8'h9F, 8, 1'b0, 1'b0, rx);
    for (int k = 0; k < 4; k++) spi_bits(8'hFF, 8, 1'b0, 1'b0, rx);
    chk("unk_busy", 32'(ifc.busy), 32'd1);
    ifc.spi_csb = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge core_clk);
    chk("unk_busy_fall", 32'(ifc.busy), 32'd0);
    cs_end();

    chk("final_strobes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
